lmsm_sequencer: RTL and testbench

Parametrised load-multiple/store-multiple micro-sequencer for the multicycle RISC datapath. Takes over the LM/SM iteration that the main controller previously ran through a fixed 8-pass counter. It walks a register bitmask of configurable width, moves each selected register to or from consecutive memory words, and stalls on a memory ready handshake. The main controller hands off on `start` and resumes on `done`.

---
 rtl/lmsm_sequencer_if.sv | 33 +++
 rtl/lmsm_sequencer.sv | 152 +++++++++++++++
 tb/tb_lmsm_sequencer.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/lmsm_sequencer_if.sv
// Register-file and memory port bundle of lmsm_sequencer.
// The master modport is the sequencer side; the slave modport is the RF/memory side.
interface lmsm_sequencer_if #(
    parameter int NREG = 8,
    parameter int AW   = 16,
    parameter int DW   = 16
);
    localparam int RW = $clog2(NREG);

    logic [RW-1:0] rf_raddr;
    logic [DW-1:0] rf_rdata;
    logic [RW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic          rf_wen;
    logic [AW-1:0] mem_addr;
    logic          mem_rd;
    logic          mem_wr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;

    modport master (
        output rf_raddr, rf_waddr, rf_wdata, rf_wen,
        output mem_addr, mem_rd, mem_wr, mem_wdata,
        input  rf_rdata, mem_rdata, mem_ready
    );

    modport slave (
        input  rf_raddr, rf_waddr, rf_wdata, rf_wen,
        input  mem_addr, mem_rd, mem_wr, mem_wdata,
        output rf_rdata, mem_rdata, mem_ready
    );
endinterface

// File: rtl/lmsm_sequencer.sv
// Load-multiple/store-multiple micro-sequencer: walks a register bitmask and moves each
// selected register to or from consecutive memory words. Define LMSM_SKIP_ZERO_EN to skip unset slots.
module lmsm_sequencer #(
    parameter int NREG = 8,
    parameter int AW   = 16,
    parameter int DW   = 16
) (
    input  logic            clk,
    input  logic            proc_rst,
    input  logic            start,
    input  logic            is_store,
    input  logic [NREG-1:0] reg_mask,
    input  logic [AW-1:0]   base_addr,
    output logic            busy,
    output logic            done,
    lmsm_sequencer_if.master bus
);
    localparam int RW = $clog2(NREG);
`ifdef LMSM_SKIP_ZERO_EN
    localparam int CW = RW;
`else
    // One extra bit so the slot counter can reach NREG, which marks the end of the walk.
    localparam int CW = RW + 1;
`endif

    typedef enum logic [2:0] {IDLE, SCAN, REQ, WB, DONE} state_t;

    state_t          state_reg, state_next;
    logic [NREG-1:0] mask_reg;
    logic [AW-1:0]   ptr_reg;
    logic [CW-1:0]   idx_reg;
    logic            store_reg;
    logic [DW-1:0]   mem_wdata_reg;
    logic [DW-1:0]   rf_wdata_reg;
    logic [RW-1:0]   rf_waddr_reg;

    logic [RW-1:0]   scan_idx;
    logic            scan_end;
    logic            scan_hit;
    logic [CW-1:0]   idx_scan_next;
    logic [CW-1:0]   idx_xfer_next;
    logic [NREG-1:0] idx_dec;

`ifdef LMSM_SKIP_ZERO_EN
    // Lowest remaining set bit wins, so each SCAN cycle lands directly on a transfer.
    always_comb begin
        scan_idx = '0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (mask_reg[i]) scan_idx = RW'(i);
        end
    end
    assign scan_end      = ~|mask_reg;
    assign scan_hit      = ~scan_end;
    assign idx_scan_next = scan_idx;
    assign idx_xfer_next = idx_reg;
`else
    assign scan_idx      = idx_reg[RW-1:0];
    assign scan_end      = (idx_reg == CW'(NREG));
    assign scan_hit      = ~scan_end & mask_reg[scan_idx];
    assign idx_scan_next = scan_hit ? idx_reg : idx_reg + CW'(1);
    assign idx_xfer_next = idx_reg + CW'(1);
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_idx_dec
            assign idx_dec[gi] = (idx_reg[RW-1:0] == RW'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (proc_rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE: if (start) state_next = SCAN;
            SCAN: begin
                if (scan_end)      state_next = DONE;
                else if (scan_hit) state_next = REQ;
            end
            REQ:  if (bus.mem_ready) state_next = store_reg ? SCAN : WB;
            WB:   state_next = SCAN;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (proc_rst) begin
            mask_reg      <= '0;
            ptr_reg       <= '0;
            idx_reg       <= '0;
            store_reg     <= 1'b0;
            mem_wdata_reg <= '0;
            rf_wdata_reg  <= '0;
            rf_waddr_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        mask_reg  <= reg_mask;
                        ptr_reg   <= base_addr;
                        store_reg <= is_store;
                        idx_reg   <= '0;
                    end
                end
                SCAN: begin
                    if (!scan_end) idx_reg <= idx_scan_next;
                    if (scan_hit && store_reg) mem_wdata_reg <= bus.rf_rdata;
                end
                REQ: begin
                    if (bus.mem_ready) begin
                        if (store_reg) begin
                            mask_reg <= mask_reg & ~idx_dec;
                            ptr_reg  <= ptr_reg + AW'(1);
                            idx_reg  <= idx_xfer_next;
                        end else begin
                            rf_wdata_reg <= bus.mem_rdata;
                            rf_waddr_reg <= idx_reg[RW-1:0];
                        end
                    end
                end
                WB: begin
                    mask_reg <= mask_reg & ~idx_dec;
                    ptr_reg  <= ptr_reg + AW'(1);
                    idx_reg  <= idx_xfer_next;
                end
                default: ;
            endcase
        end
    end

    // Strobes and the address are decoded from state so an abandoned access drops at once.
    always_comb begin
        busy          = (state_reg != IDLE);
        done          = (state_reg == DONE);
        bus.rf_raddr  = (state_reg == SCAN) ? scan_idx : '0;
        bus.rf_waddr  = rf_waddr_reg;
        bus.rf_wdata  = rf_wdata_reg;
        bus.rf_wen    = (state_reg == WB);
        bus.mem_addr  = (state_reg == REQ) ? ptr_reg : '0;
        bus.mem_rd    = (state_reg == REQ) && !store_reg;
        bus.mem_wr    = (state_reg == REQ) && store_reg;
        bus.mem_wdata = mem_wdata_reg;
    end
endmodule

// File: tb/tb_lmsm_sequencer.sv
// Self-checking bench for lmsm_sequencer: table of LM/SM sequences, scoreboard of expected
// RF/memory writes, and cycle-exact done/busy/stall/reset checks.
module tb_lmsm_sequencer;
`ifdef LMSM_SKIP_ZERO_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif
    localparam int NV = 10;

    typedef struct {
        bit          store;
        logic [7:0]  mask;
        logic [15:0] base;
        int          exp_done;
        int          stall_lo;
        int          stall_hi;
        int          rst_cyc;
        bit          restart;
        int          nmax;
    } vec_t;

    typedef struct {
        bit          is_mem;
        logic [15:0] addr;
        logic [15:0] data;
    } exp_t;

    logic        clk;
    logic        proc_rst;
    logic        start;
    logic        is_store;
    logic [7:0]  reg_mask;
    logic [15:0] base_addr;
    logic        busy;
    logic        done;
    logic        ready;

    int   total = 0;
    int   passed = 0;
    int   both_seen = 0;
    exp_t sb[$];
    vec_t vecs[NV];

    lmsm_sequencer_if #(.NREG(8), .AW(16), .DW(16)) bus ();

    lmsm_sequencer #(.NREG(8), .AW(16), .DW(16)) dut (
        .clk       (clk),
        .proc_rst  (proc_rst),
        .start     (start),
        .is_store  (is_store),
        .reg_mask  (reg_mask),
        .base_addr (base_addr),
        .busy      (busy),
        .done      (done),
        .bus       (bus)
    );

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A5A;
    endfunction

    // Load data is poisoned while not ready so an early capture shows up as wrong data.
    assign bus.rf_rdata  = 16'h1000 + 16'(bus.rf_raddr);
    assign bus.mem_rdata = ready ? mem_word(bus.mem_addr) : 16'hDEAD;
    assign bus.mem_ready = ready;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %h, required %h", name, act, req);
    endtask

    task automatic observe(input bit is_mem, input logic [15:0] a, input logic [15:0] d);
        exp_t e;
        total++;
        if (sb.size() == 0) begin
            $display("FAIL sb_unexpected: got %s a=%h d=%h, required no transfer",
                     is_mem ? "MEMW" : "RFW", a, d);
            return;
        end
        e = sb.pop_front();
        if (e.is_mem !== is_mem || e.addr !== a || e.data !== d) begin
            $display("FAIL sb_xfer: got %s a=%h d=%h, required %s a=%h d=%h",
                     is_mem ? "MEMW" : "RFW", a, d, e.is_mem ? "MEMW" : "RFW", e.addr, e.data);
        end else begin
            passed++;
            $display("xfer ok %s a=%h d=%h", is_mem ? "MEMW" : "RFW", a, d);
        end
    endtask

    // Transfer monitor; an RF held in reset does not take the write.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.mem_rd && bus.mem_wr) both_seen++;
            if (bus.rf_wen && !proc_rst) observe(1'b0, 16'(bus.rf_waddr), bus.rf_wdata);
            if (bus.mem_wr && bus.mem_ready) observe(1'b1, bus.mem_addr, bus.mem_wdata);
        end
    end

    task automatic run_vec(input int vi, input vec_t v);
        int   n;
        int   cyc;
        bit   finished;
        exp_t e;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            if (v.mask[i] && n < v.nmax) begin
                e.is_mem = v.store;
                e.addr   = v.store ? v.base + 16'(n) : 16'(i);
                e.data   = v.store ? 16'h1000 + 16'(i) : mem_word(v.base + 16'(n));
                sb.push_back(e);
                n++;
            end
        end
        @(posedge clk); #1;
        start = 1'b1; is_store = v.store; reg_mask = v.mask; base_addr = v.base;
        @(posedge clk); #1;
        start = 1'b0; is_store = ~v.store; reg_mask = ~v.mask; base_addr = ~v.base;
        cyc = 1;
        finished = 1'b0;
        while (!finished && cyc < 200) begin
            ready    = !(cyc >= v.stall_lo && cyc <= v.stall_hi);
            start    = v.restart && cyc >= 2 && cyc <= v.exp_done;
            proc_rst = (cyc == v.rst_cyc);
            @(negedge clk);
            if (cyc == 1) chk("busy_first_scan", 32'(busy), 32'd1);
            if (v.stall_hi >= v.stall_lo && cyc >= v.stall_lo && cyc <= v.stall_hi + 1) begin
                chk("stall_rd_held", 32'(bus.mem_rd), 32'd1);
                chk("stall_addr_held", 32'(bus.mem_addr), 32'(v.base));
            end
            if (v.rst_cyc != 0 && cyc == v.rst_cyc) chk("wen_in_wb", 32'(bus.rf_wen), 32'd1);
            if (v.rst_cyc != 0 && cyc == v.rst_cyc + 1) begin
                chk("wen_after_rst", 32'(bus.rf_wen), 32'd0);
                chk("busy_after_rst", 32'(busy), 32'd0);
                chk("mem_strobes_after_rst", 32'({bus.mem_rd, bus.mem_wr}), 32'd0);
                finished = 1'b1;
            end
            if (done) begin
                chk("done_cycle", 32'(cyc), 32'(v.exp_done));
                finished = 1'b1;
            end else if (v.exp_done != 0 && cyc > v.exp_done) begin
                chk("done_seen", 32'd0, 32'd1);
                finished = 1'b1;
            end
            @(posedge clk); #1;
            cyc++;
        end
        if (!finished) chk("seq_timeout", 32'd0, 32'd1);
        start = 1'b0; proc_rst = 1'b0; ready = 1'b1;
        @(negedge clk);
        chk("busy_after_done", 32'(busy), 32'd0);
        chk("done_single_a", 32'(done), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("done_single_b", 32'(done), 32'd0);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        sb.delete();
        $display("vec %0d store=%0d mask=%h base=%h finished", vi, v.store, v.mask, v.base);
    endtask

    initial begin
        //              store mask   base      done(skip/noskip)      stall   rst rs nmax
        vecs[0] = '{1'b0, 8'h85, 16'h0040, SKIP ? 11 : 16, 0, -1, 0, 1'b0, 99};
        vecs[1] = '{1'b1, 8'hFF, 16'hFFFE, 18,              0, -1, 0, 1'b0, 99};
        vecs[2] = '{1'b0, 8'h00, 16'h0123, SKIP ? 2 : 10,   0, -1, 0, 1'b0, 99};
        vecs[3] = '{1'b1, 8'h00, 16'h0456, SKIP ? 2 : 10,   0, -1, 0, 1'b0, 99};
        vecs[4] = '{1'b0, 8'h01, 16'h1234, SKIP ? 8 : 15,   2, 4,  0, 1'b0, 99};
        vecs[5] = '{1'b0, 8'h0F, 16'h0100, 0,               0, -1, 6, 1'b0, 1};
        vecs[6] = '{1'b1, 8'h52, 16'h0200, SKIP ? 8 : 13,   0, -1, 0, 1'b1, 99};
        vecs[7] = '{1'b0, 8'h80, 16'hFFFF, SKIP ? 5 : 12,   0, -1, 0, 1'b0, 99};
        vecs[8] = '{1'b1, 8'h01, 16'h0000, SKIP ? 4 : 11,   0, -1, 0, 1'b0, 99};
        vecs[9] = '{1'b0, 8'hFF, 16'h7FFE, 26,              0, -1, 0, 1'b0, 99};

        proc_rst = 1'b1; start = 1'b0; is_store = 1'b0;
        reg_mask = 8'h00; base_addr = 16'h0000; ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_strobes", 32'({bus.rf_wen, bus.mem_rd, bus.mem_wr}), 32'd0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
        chk("rst_rf_w", 32'({bus.rf_waddr, bus.rf_wdata}), 32'd0);
        chk("rst_rf_raddr", 32'(bus.rf_raddr), 32'd0);
        @(posedge clk); #1;
        proc_rst = 1'b0;

        for (int v = 0; v < NV; v++) run_vec(v, vecs[v]);

        chk("rd_wr_exclusive", 32'(both_seen), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
